// File: rtl/bit_reverse_seq.sv
// Handshaked bit-reversal engine: reverses the low m bits of an operand one bit per clock
// and zeroes everything above them. Requests enter on a valid/ready port, results leave on another.
module bit_reverse_seq #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_b,
   input  logic [W-1:0] in_m,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_result,
   output logic         busy
);

   localparam int             CW    = $clog2(W + 1);
   localparam logic [W-1:0]   M_MAX = W[W-1:0];
   localparam logic [CW-1:0]  M_SAT = CW'(W);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] m_eff;

   // Requests longer than the operand saturate to a full-width reversal.
   assign m_eff = (in_m > M_MAX) ? M_SAT : in_m[CW-1:0];

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: the datapath registers are reset too, so out_result reads 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sh_d    = in_b;
               acc_d   = '0;
               cnt_d   = m_eff;
               state_d = (m_eff == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            acc_d = {acc_q[W-2:0], sh_q[0]};
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decode state only; no input reaches an output combinationally.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   assign out_result = acc_q;

endmodule

// File: tb/tb_bit_reverse_seq.sv
// Self-checking bench for bit_reverse_seq: directed cases from the feature list plus randomized
// requests, compared against an index-mapping reference model.
module tb_bit_reverse_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_b;
   logic [31:0] in_m;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;

   bit_reverse_seq #(.W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_b       (in_b),
      .in_m       (in_m),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: m_eff = min(m, 32), result bit (m_eff-1-i) takes operand bit i.
   function automatic int ref_meff(input logic [31:0] m);
      return (m > 32'd32) ? 32 : int'(m);
   endfunction

   function automatic logic [31:0] ref_rev(input logic [31:0] b, input logic [31:0] m);
      logic [31:0] r;
      int me;
      me = ref_meff(m);
      r  = '0;
      for (int i = 0; i < me; i++) r[me-1-i] = b[i];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full request. stall < 0 holds out_ready high throughout; otherwise out_ready stays
   // low for 'stall' cycles after out_valid rises. With pend set, a second request is
   // presented during the stall and left asserted for the next call to accept.
   task automatic req(input string tag, input logic [31:0] b, input logic [31:0] m,
                      input int stall, input bit pend,
                      input logic [31:0] pb, input logic [31:0] pm);
      logic [31:0] exp;
      int n;
      exp = ref_rev(b, m);
      check({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_b      = b;
      in_m      = m;
      out_ready = (stall < 0);
      tick();
      in_valid = 1'b0;
      in_b     = $urandom;
      in_m     = $urandom;
      n = 0;
      while (!out_valid && n < 100) begin
         check({tag, "_busy_shift"}, {31'd0, busy}, 32'd1);
         tick();
         n++;
      end
      check({tag, "_latency"}, n, ref_meff(m));
      check({tag, "_result"}, out_result, exp);
      check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
      if (stall > 0) begin
         if (pend) begin
            in_valid = 1'b1;
            in_b     = pb;
            in_m     = pm;
         end
         for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_stall_result"}, out_result, exp);
            check({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_in_ready_after_hs"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_busy_after_hs"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      bit saw_valid;
      logic [31:0] rb, rm;
      int st;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_b      = '0;
      in_m      = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", out_result, 32'd0);

      req("m4", 32'h0000_000B, 32'd4, 0, 1'b0, '0, '0);
      check("m4_ref", ref_rev(32'h0000_000B, 32'd4), 32'h0000_000D);
      req("m32", 32'h0000_0001, 32'd32, 0, 1'b0, '0, '0);
      req("m40", 32'h0000_0001, 32'd40, 0, 1'b0, '0, '0);
      req("upper_ignored", 32'hFFFF_FFF0, 32'd4, 0, 1'b0, '0, '0);
      req("m0", 32'hDEAD_BEEF, 32'd0, 0, 1'b0, '0, '0);
      req("m0_rdy_high", 32'h1234_5678, 32'd0, -1, 1'b0, '0, '0);
      req("rdy_high", 32'hA5A5_0F0F, 32'd7, -1, 1'b0, '0, '0);

      req("bp", 32'h1234_5678, 32'd32, 10, 1'b1, 32'h0000_00F1, 32'd8);
      req("bp_pending", 32'h0000_00F1, 32'd8, 0, 1'b0, '0, '0);

      // Reset in the middle of a long operation must discard it.
      in_valid = 1'b1;
      in_b     = 32'hCAFE_F00D;
      in_m     = 32'd16;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_result", out_result, 32'd0);
      saw_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (out_valid) saw_valid = 1'b1;
      end
      check("midrst_no_stale", {31'd0, saw_valid}, 32'd0);
      req("after_rst", 32'h0000_0001, 32'd1, 0, 1'b0, '0, '0);

      for (int t = 0; t < 25; t++) begin
         rb = $urandom;
         rm = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 34));
         st = int'($urandom_range(0, 4)) - 1;
         req("rand", rb, rm, st, 1'b0, '0, '0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
